// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Iterative unsigned shift-and-add multiplier. Each RUN cycle adds the
//   captured multiplicand into the upper half of a right-shifting accumulator
//   with a WIDTH+1-bit add, so the carry-out becomes the new MSB.
//   Uses a start/busy/done handshake. The product register holds its value
//   until the next operation completes.
//
//   Optional build macro: SHIFT_ADD_EARLY_TERM_EN. When it is defined, RUN
//   ends early as soon as the remaining multiplier bits are all zero. The
//   product is the same in both builds.
//
// Parameters
//   WIDTH         operand width (>= 2); the product is 2*WIDTH bits
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         request; sampled only in IDLE
//   multiplicand  operand A, captured when start is accepted
//   multiplier    operand B, captured when start is accepted
//   product       registered A*B, held between operations
//   busy          high while in RUN
//   done          one-cycle pulse in DONE; product is valid from that cycle
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic [2*WIDTH-1:0]     product,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_upd;
    logic [CW-1:0]        count;
    logic [WIDTH:0]       sum;
    logic                 finish;
    logic [2*WIDTH-1:0]   result;

    // One partial-product step; the carry of the add shifts into the MSB.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
        acc_upd = {sum, acc[WIDTH-1:1]};
    end

`ifdef SHIFT_ADD_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;

    // After this step, the low count-1 bits of acc_upd are the multiplier
    // bits not yet consumed. The bits above them are already product bits.
    // If every remaining bit is zero, the remaining steps would only shift
    // right, so that shift is applied here in one go.
    always_comb begin
        rem_mask = (WIDTH'(1) << (count - CW'(1))) - WIDTH'(1);
        finish   = (count == CW'(1)) || ((acc_upd[WIDTH-1:0] & rem_mask) == '0);
        result   = acc_upd >> (count - CW'(1));
    end
`else
    always_comb begin
        finish = (count == CW'(1));
        result = acc_upd;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)  state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= {{WIDTH{1'b0}}, multiplier};
                        count <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    acc   <= acc_upd;
                    count <= count - CW'(1);
                    if (finish) product <= result;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int W = 4;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        logic [2*W-1:0] p;
        int             lat;
        string          name;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    exp_t           exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             busy_cnt = 0;
    bit             prev_done = 1'b0;
    bit             rst_seen = 1'b0;
    logic [2*W-1:0] prev_product = '0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge rst) rst_seen = 1'b1;

    // Monitor: pops one expectation per done pulse and compares the product
    // and the number of busy cycles. It also checks that product never moves
    // except on a done cycle.
    always @(negedge clk) begin
        if (rst || rst_seen) begin
            rst_seen     = 1'b0;
            busy_cnt     = 0;
            prev_done    = 1'b0;
            prev_product = product;
        end else begin
            if (busy) busy_cnt++;
            if (!done) check("product_hold", int'(product), int'(prev_product));
            if (prev_done) check("done_width", int'(done), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: product %0h with empty queue", product);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_product"}, int'(product), int'(e.p));
                    check({e.name, "_busy_cycles"}, busy_cnt, e.lat);
                end
                busy_cnt = 0;
            end
            prev_done    = done;
            prev_product = product;
        end
    end

    task automatic wait_done(input string name, output longint t);
        bit ok = 1'b0;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                t  = $time / 10;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: done not seen, required within 40 cycles", name);
        end
    endtask

    task automatic push(input int p, input int lat_def, input int lat_et, input string name);
        exp_t e;
        e.p    = (2*W)'(p);
        e.lat  = ET ? lat_et : lat_def;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_op(input int a, input int b, input int p,
                         input int lat_def, input int lat_et, input string name);
        longint t;
        @(negedge clk);
        multiplicand = W'(a);
        multiplier   = W'(b);
        start        = 1'b1;
        push(p, lat_def, lat_et, name);
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = ~W'(a);
        multiplier   = ~W'(b);
        wait_done(name, t);
    endtask

    initial begin
        longint t1, t2;

        // Reset state
        #12;
        check("reset_product", int'(product), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        #5 rst = 1'b0;

        // Basic, carry path, mixed operands
        do_op(4'hB, 4'hB, 8'h79, 4, 4, "t1_b_x_b");
        do_op(4'hF, 4'hF, 8'hE1, 4, 4, "t2_f_x_f");
        do_op(4'h3, 4'hE, 8'h2A, 4, 4, "t2_3_x_e");

        // start re-pulsed during RUN and during DONE is ignored
        @(negedge clk);
        multiplicand = 4'h5;
        multiplier   = 4'h6;
        start        = 1'b1;
        push(8'h1E, 4, 3, "t3_5_x_6");
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        multiplicand = 4'h7;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3", t1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        // start held high: back-to-back operations
        @(negedge clk);
        multiplicand = 4'h2;
        multiplier   = 4'h8;
        start        = 1'b1;
        push(8'h10, 4, 4, "t4_2_x_8");
        push(8'h32, 4, 3, "t4_a_x_5");
        @(posedge clk);
        #1;
        multiplicand = 4'hA;
        multiplier   = 4'h5;
        wait_done("t4a", t1);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        multiplicand = 4'h0;
        multiplier   = 4'h0;
        wait_done("t4b", t2);
        check("t4_done_spacing", int'(t2 - t1), (ET ? 3 : 4) + 2);

        // Asynchronous reset in the second RUN cycle aborts the operation
        @(negedge clk);
        multiplicand = 4'h3;
        multiplier   = 4'h5;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_abort_product", int'(product), 0);
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_done", int'(done), 0);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(4'h3, 4'h5, 8'h0F, 4, 3, "t5_after_reset");

        // Short multipliers (early termination when enabled)
        do_op(4'h9, 4'h1, 8'h09, 4, 1, "t6_9_x_1");
        do_op(4'h9, 4'h0, 8'h00, 4, 1, "t6_9_x_0");

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
